tv80_reg_seq: RTL and testbench
===============================

TV80_REG_SEQ -- requirements
Module: tv80_reg_seq

Interface
REQ-001 The module SHALL have one clock, clk, and a synchronous, active-high reset, reset; all state changes occur on the rising edge of clk.
REQ-002 Ports SHALL be (name  direction  width  meaning):
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- cen  in  1  clock enable; low = stall
- req  in  1  operation request
- op  in  3  operation code
- addr_x  in  3  primary register-pair index
- addr_y  in  3  secondary pair index (XCHG only)
- wdata  in  16  write data, high byte in [15:8]
- ready  out  1  idle, able to accept a request
- busy  out  1  operation in progress
- done  out  1  one-cycle completion pulse
- err  out  1  reserved op flag, valid with done
- result  out  16  last value written to pair x
- zero  out  1  result==0, valid with done
- rf_addr_a  out  3  register-file write/read port A address
- rf_addr_b  out  3  register-file read port B address
- rf_dih  out  8  register-file write data, high byte
- rf_dil  out  8  register-file write data, low byte
- rf_weh  out  1  register-file high-byte write enable
- rf_wel  out  1  register-file low-byte write enable
- rf_cen  out  1  register-file clock enable
- rf_doah, rf_doal  in  8 each  asynchronous read data, port A
- rf_dobh, rf_dobl  in  8 each  asynchronous read data, port B
REQ-003 Op encoding SHALL be:
- 000 NOP
- 001 WR8H
- 010 WR8L
- 011 WR16
- 100 INC16
- 101 DEC16
- 110 XCHG
- 111 reserved

Function
REQ-004 States SHALL be IDLE, EXEC, XCH2 and DONE; ready=1 only in IDLE; busy=1 only in EXEC and XCH2; done=1 only in DONE.
REQ-005 A request SHALL be accepted on an edge where state=IDLE, req=1 and cen=1; at acceptance op, addr_x, addr_y and wdata are latched and the state becomes EXEC.
REQ-006 req while not in IDLE SHALL be ignored and not queued.
REQ-007 In EXEC, rf_addr_a SHALL equal the latched x and rf_addr_b the latched y; write enables are combinational from state and latched op.
REQ-008 Per-op behaviour in EXEC SHALL be:
- WR8H: rf_weh=1, rf_dih=wdata[15:8].
- WR8L: rf_wel=1, rf_dil=wdata[7:0].
- WR16: both enables asserted, data = wdata.
- INC16/DEC16: both enables asserted, data = {rf_doah,rf_doal} plus/minus 1, modulo 2^16.
- NOP/reserved: no enables asserted.
REQ-009 XCHG SHALL write pair x with {rf_dobh,rf_dobl} in EXEC and capture {rf_doah,rf_doal} into a temp register; in XCH2 it SHALL write pair y (rf_addr_a=y) with temp, both enables asserted.
REQ-010 After EXEC, the next state SHALL be XCH2 for XCHG and DONE for all other ops; after XCH2 it SHALL be DONE; after DONE it SHALL be IDLE.
- Latency from acceptance to done: 2 cycles, or 3 cycles for XCHG.
REQ-011 On the write to pair x, result SHALL latch the 16-bit value written; unwritten bytes are taken from rf_doa.
- zero SHALL latch (value==0).
- NOP and reserved ops SHALL leave result unchanged.
REQ-012 err SHALL be 1 in the DONE cycle of a reserved op and 0 otherwise.
REQ-013 With cen=0 the state and all latches SHALL hold, and rf_weh=rf_wel=0; done and busy hold their values.
REQ-014 rf_cen SHALL equal cen.
REQ-015 Wrap-around SHALL behave as follows:
- INC16 of 0xFFFF writes 0x0000 with zero=1.
- DEC16 of 0x0000 writes 0xFFFF with zero=0.
- DEC16 of 0x0001 writes 0x0000 with zero=1.
REQ-016 XCHG with x==y SHALL perform both writes and leave the pair unchanged.
- result = the original value.

Reset
REQ-017 While reset=1 (regardless of cen) the state SHALL go to IDLE and output reset values: ready=1, busy=0, done=0, err=0, result=0x0000, zero=0, rf_weh=rf_wel=0.
- Latched op, addresses, data and temp SHALL be cleared to 0.
REQ-018 Reset during EXEC or XCH2 SHALL abort the operation with no write in the reset cycle.
- An aborted XCHG may leave pair x written and pair y unwritten.
REQ-019 The first request SHALL be accepted on the first edge after reset deasserts.

Verification
REQ-020 WR16 x=2, wdata=0xBEEF -> EXEC with rf_addr_a=2, weh=wel=1, data 0xBE/0xEF; done two cycles after acceptance; result=0xBEEF.
REQ-021 Pair 1 = 0xFFFF, INC16 x=1 -> pair 1 written 0x0000, zero=1; then DEC16 x=1 -> writes 0xFFFF, zero=0.
REQ-022 Pair 0 = 0x1234, pair 2 = 0xABCD, XCHG x=0 y=2:
- EXEC writes addr 0 with 0xABCD.
- XCH2 writes addr 2 with 0x1234.
- done on the third cycle after acceptance.
REQ-023 WR8L x=3, wdata=0x55AA with pair 3 = 0x7700 -> only wel=1, dil=0xAA; result=0x77AA.
REQ-024 cen=0 held 4 cycles mid-XCHG -> no write enables and state frozen; on cen=1 it resumes with identical writes.
- req during busy is ignored.
REQ-025 reset asserted in the XCH2 cycle -> no write that cycle; next cycle ready=1 and done=0.
- op=111 -> no writes, done with err=1.

Source files
------------

// File: rtl/tv80_reg_seq.sv
// tv80_reg_seq: sequencer for 16-bit register-pair operations on a TV80-style
// register file with byte write enables and two asynchronous read ports.
//
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   cen                 clock enable (low = stall, state and latches hold)
//   req, op, addr_x,    request handshake; op/addresses/data are latched
//   addr_y, wdata       when a request is accepted in IDLE
//   ready, busy, done   IDLE / EXEC-or-XCH2 / DONE status (registered)
//   err                 reserved op indicator, valid with done
//   result, zero        last value written to pair x and its zero flag
//   rf_addr_a/b         register-file port A (write/read) and B (read) address
//   rf_dih/dil          register-file write data, high/low byte
//   rf_weh/wel          register-file byte write enables
//   rf_cen              register-file clock enable (mirrors cen)
//   rf_doah/l, dobh/l   asynchronous read data from ports A and B
module tv80_reg_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        cen,
  input  logic        req,
  input  logic [2:0]  op,
  input  logic [2:0]  addr_x,
  input  logic [2:0]  addr_y,
  input  logic [15:0] wdata,
  output logic        ready,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] result,
  output logic        zero,
  output logic [2:0]  rf_addr_a,
  output logic [2:0]  rf_addr_b,
  output logic [7:0]  rf_dih,
  output logic [7:0]  rf_dil,
  output logic        rf_weh,
  output logic        rf_wel,
  output logic        rf_cen,
  input  logic [7:0]  rf_doah,
  input  logic [7:0]  rf_doal,
  input  logic [7:0]  rf_dobh,
  input  logic [7:0]  rf_dobl
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_XCH2 = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_WR8H  = 3'd1;
  localparam logic [2:0] OP_WR8L  = 3'd2;
  localparam logic [2:0] OP_WR16  = 3'd3;
  localparam logic [2:0] OP_INC16 = 3'd4;
  localparam logic [2:0] OP_DEC16 = 3'd5;
  localparam logic [2:0] OP_XCHG  = 3'd6;
  localparam logic [2:0] OP_RSVD  = 3'd7;

  state_t      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [2:0]  x_q, x_d;
  logic [2:0]  y_q, y_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] temp_q, temp_d;
  logic [15:0] result_q, result_d;
  logic        zero_q, zero_d;
  logic        ready_q, ready_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic [15:0] doa_s;
  logic [15:0] dob_s;
  logic [15:0] wr_val_s;
  logic        we_h_s;
  logic        we_l_s;
  logic [2:0]  addr_a_s;

  assign doa_s = {rf_doah, rf_doal};
  assign dob_s = {rf_dobh, rf_dobl};

  // Write datapath: address, data and byte enables for the current state.
  // Bytes that are not written carry port-A read data so wr_val_s is always
  // the full 16-bit pair value after the write.
  always_comb begin
    wr_val_s = doa_s;
    we_h_s   = 1'b0;
    we_l_s   = 1'b0;
    addr_a_s = x_q;
    case (state_q)
      S_EXEC: begin
        case (op_q)
          OP_WR8H: begin
            wr_val_s = {wdata_q[15:8], doa_s[7:0]};
            we_h_s   = 1'b1;
          end
          OP_WR8L: begin
            wr_val_s = {doa_s[15:8], wdata_q[7:0]};
            we_l_s   = 1'b1;
          end
          OP_WR16: begin
            wr_val_s = wdata_q;
            we_h_s   = 1'b1;
            we_l_s   = 1'b1;
          end
          OP_INC16: begin
            wr_val_s = doa_s + 16'd1;
            we_h_s   = 1'b1;
            we_l_s   = 1'b1;
          end
          OP_DEC16: begin
            wr_val_s = doa_s - 16'd1;
            we_h_s   = 1'b1;
            we_l_s   = 1'b1;
          end
          OP_XCHG: begin
            wr_val_s = dob_s;
            we_h_s   = 1'b1;
            we_l_s   = 1'b1;
          end
          default: begin
            wr_val_s = doa_s;
            we_h_s   = 1'b0;
            we_l_s   = 1'b0;
          end
        endcase
      end
      S_XCH2: begin
        // second half of XCHG: port A now points at pair y
        addr_a_s = y_q;
        wr_val_s = temp_q;
        we_h_s   = 1'b1;
        we_l_s   = 1'b1;
      end
      default: begin
        addr_a_s = x_q;
        wr_val_s = doa_s;
        we_h_s   = 1'b0;
        we_l_s   = 1'b0;
      end
    endcase
  end

  // No write during a stall or in a reset cycle (reset aborts the operation).
  assign rf_weh    = we_h_s & cen & ~reset;
  assign rf_wel    = we_l_s & cen & ~reset;
  assign rf_addr_a = addr_a_s;
  assign rf_addr_b = y_q;
  assign rf_dih    = wr_val_s[15:8];
  assign rf_dil    = wr_val_s[7:0];
  assign rf_cen    = cen;

  assign ready  = ready_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign err    = err_q;
  assign result = result_q;
  assign zero   = zero_q;

  // Next-state logic: FSM transitions, request latching and status outputs.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    x_d      = x_q;
    y_d      = y_q;
    wdata_d  = wdata_q;
    temp_d   = temp_q;
    result_d = result_q;
    zero_d   = zero_q;
    ready_d  = ready_q;
    busy_d   = busy_q;
    done_d   = done_q;
    err_d    = err_q;
    if (cen) begin
      case (state_q)
        S_IDLE: begin
          if (req) begin
            op_d    = op;
            x_d     = addr_x;
            y_d     = addr_y;
            wdata_d = wdata;
            state_d = S_EXEC;
            ready_d = 1'b0;
            busy_d  = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_EXEC: begin
          // every op except NOP/reserved writes pair x in this cycle
          if ((op_q != OP_NOP) && (op_q != OP_RSVD)) begin
            result_d = wr_val_s;
            zero_d   = (wr_val_s == 16'd0);
          end else begin
            result_d = result_q;
          end
          if (op_q == OP_XCHG) begin
            temp_d  = doa_s;
            state_d = S_XCH2;
          end else begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            err_d   = (op_q == OP_RSVD);
          end
        end
        S_XCH2: begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          err_d   = 1'b0;
        end
        S_DONE: begin
          state_d = S_IDLE;
          ready_d = 1'b1;
          done_d  = 1'b0;
          err_d   = 1'b0;
        end
        default: begin
          state_d = S_IDLE;
          ready_d = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b0;
          err_d   = 1'b0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State and latch registers; reset wins over cen.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      op_q     <= 3'd0;
      x_q      <= 3'd0;
      y_q      <= 3'd0;
      wdata_q  <= 16'd0;
      temp_q   <= 16'd0;
      result_q <= 16'd0;
      zero_q   <= 1'b0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      x_q      <= x_d;
      y_q      <= y_d;
      wdata_q  <= wdata_d;
      temp_q   <= temp_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_tv80_reg_seq.sv
// Self-checking bench for tv80_reg_seq: a behavioural register file, a table
// of directed operations with hand-computed results, and hand-written
// sequences for stall, reset abort and first-request-after-reset.
module tb_tv80_reg_seq;

  logic        clk = 1'b0;
  logic        reset, cen, req;
  logic [2:0]  op, addr_x, addr_y;
  logic [15:0] wdata;
  logic        ready, busy, done, err, zero;
  logic [15:0] result;
  logic [2:0]  rf_addr_a, rf_addr_b;
  logic [7:0]  rf_dih, rf_dil;
  logic        rf_weh, rf_wel, rf_cen;
  logic [7:0]  rf_doah, rf_doal, rf_dobh, rf_dobl;

  logic [15:0] mem [8];
  int          nweh, nwel;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  tv80_reg_seq dut (
    .clk(clk), .reset(reset), .cen(cen), .req(req), .op(op),
    .addr_x(addr_x), .addr_y(addr_y), .wdata(wdata),
    .ready(ready), .busy(busy), .done(done), .err(err),
    .result(result), .zero(zero),
    .rf_addr_a(rf_addr_a), .rf_addr_b(rf_addr_b),
    .rf_dih(rf_dih), .rf_dil(rf_dil), .rf_weh(rf_weh), .rf_wel(rf_wel),
    .rf_cen(rf_cen),
    .rf_doah(rf_doah), .rf_doal(rf_doal), .rf_dobh(rf_dobh), .rf_dobl(rf_dobl)
  );

  // register file model: async read, byte-enabled synchronous write
  assign rf_doah = mem[rf_addr_a][15:8];
  assign rf_doal = mem[rf_addr_a][7:0];
  assign rf_dobh = mem[rf_addr_b][15:8];
  assign rf_dobl = mem[rf_addr_b][7:0];

  always @(posedge clk) begin
    if (rf_cen && rf_weh) begin
      mem[rf_addr_a][15:8] <= rf_dih;
      nweh <= nweh + 1;
    end
    if (rf_cen && rf_wel) begin
      mem[rf_addr_a][7:0] <= rf_dil;
      nwel <= nwel + 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // issue one request and wait (bounded) for done; lat counts cycles from acceptance
  task automatic do_op(input logic [2:0] o, input logic [2:0] x, input logic [2:0] y,
                       input logic [15:0] wd, output int lat);
    @(negedge clk);
    nweh = 0;
    nwel = 0;
    req = 1'b1; op = o; addr_x = x; addr_y = y; wdata = wd;
    @(negedge clk);
    req = 1'b0;
    lat = 1;
    while (!done && lat < 10) begin
      @(negedge clk);
      lat++;
    end
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [2:0]  x;
    logic [2:0]  y;
    logic [15:0] wd;
    logic [15:0] res;
    logic        z;
    logic        e;
    int          lat;
    logic [15:0] px;
    logic [15:0] py;
    int          nh;
    int          nl;
  } vec_t;

  vec_t vecs [16];
  int   lat;

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 16'h0000;
    nweh = 0; nwel = 0;
    reset = 1'b1; cen = 1'b1; req = 1'b0;
    op = 3'd0; addr_x = 3'd0; addr_y = 3'd0; wdata = 16'h0000;

    //            op    x     y     wdata     result    z     e     lat px        py        nh nl
    vecs[0]  = '{3'd3, 3'd1, 3'd1, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 2, 16'hFFFF, 16'hFFFF, 1, 1};
    vecs[1]  = '{3'd4, 3'd1, 3'd1, 16'h0000, 16'h0000, 1'b1, 1'b0, 2, 16'h0000, 16'h0000, 1, 1};
    vecs[2]  = '{3'd5, 3'd1, 3'd1, 16'h0000, 16'hFFFF, 1'b0, 1'b0, 2, 16'hFFFF, 16'hFFFF, 1, 1};
    vecs[3]  = '{3'd3, 3'd4, 3'd4, 16'h0001, 16'h0001, 1'b0, 1'b0, 2, 16'h0001, 16'h0001, 1, 1};
    vecs[4]  = '{3'd5, 3'd4, 3'd4, 16'h0000, 16'h0000, 1'b1, 1'b0, 2, 16'h0000, 16'h0000, 1, 1};
    vecs[5]  = '{3'd3, 3'd0, 3'd0, 16'h1234, 16'h1234, 1'b0, 1'b0, 2, 16'h1234, 16'h1234, 1, 1};
    vecs[6]  = '{3'd3, 3'd2, 3'd2, 16'hABCD, 16'hABCD, 1'b0, 1'b0, 2, 16'hABCD, 16'hABCD, 1, 1};
    vecs[7]  = '{3'd6, 3'd0, 3'd2, 16'h0000, 16'hABCD, 1'b0, 1'b0, 3, 16'hABCD, 16'h1234, 2, 2};
    vecs[8]  = '{3'd3, 3'd3, 3'd3, 16'h7700, 16'h7700, 1'b0, 1'b0, 2, 16'h7700, 16'h7700, 1, 1};
    vecs[9]  = '{3'd2, 3'd3, 3'd3, 16'h55AA, 16'h77AA, 1'b0, 1'b0, 2, 16'h77AA, 16'h77AA, 0, 1};
    vecs[10] = '{3'd1, 3'd3, 3'd3, 16'h12FF, 16'h12AA, 1'b0, 1'b0, 2, 16'h12AA, 16'h12AA, 1, 0};
    vecs[11] = '{3'd0, 3'd3, 3'd3, 16'h0000, 16'h12AA, 1'b0, 1'b0, 2, 16'h12AA, 16'h12AA, 0, 0};
    vecs[12] = '{3'd7, 3'd3, 3'd3, 16'h0000, 16'h12AA, 1'b0, 1'b1, 2, 16'h12AA, 16'h12AA, 0, 0};
    vecs[13] = '{3'd3, 3'd5, 3'd5, 16'hCAFE, 16'hCAFE, 1'b0, 1'b0, 2, 16'hCAFE, 16'hCAFE, 1, 1};
    vecs[14] = '{3'd6, 3'd5, 3'd5, 16'h0000, 16'hCAFE, 1'b0, 1'b0, 3, 16'hCAFE, 16'hCAFE, 2, 2};
    vecs[15] = '{3'd4, 3'd6, 3'd6, 16'h0000, 16'h0001, 1'b0, 1'b0, 2, 16'h0001, 16'h0001, 1, 1};

    // reset values
    repeat (2) @(negedge clk);
    chk("rst_ready", ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_result", result, 16'h0000);
    chk("rst_zero", zero, 1'b0);
    chk("rst_we", {rf_weh, rf_wel}, 2'b00);

    // WR16 issued together with reset release: accepted on the first edge
    reset = 1'b0;
    req = 1'b1; op = 3'd3; addr_x = 3'd2; addr_y = 3'd0; wdata = 16'hBEEF;
    @(negedge clk);
    req = 1'b0;
    #1;
    chk("wr16_busy", busy, 1'b1);
    chk("wr16_ready", ready, 1'b0);
    chk("wr16_addr_a", rf_addr_a, 3'd2);
    chk("wr16_we", {rf_weh, rf_wel}, 2'b11);
    chk("wr16_data", {rf_dih, rf_dil}, 16'hBEEF);
    chk("wr16_rf_cen", rf_cen, 1'b1);
    @(negedge clk);
    chk("wr16_done", done, 1'b1);
    chk("wr16_result", result, 16'hBEEF);
    chk("wr16_mem", mem[2], 16'hBEEF);
    @(negedge clk);
    chk("wr16_idle", {ready, done, busy}, 3'b100);

    // table-driven operations
    for (int i = 0; i < 16; i++) begin
      do_op(vecs[i].op, vecs[i].x, vecs[i].y, vecs[i].wd, lat);
      chk($sformatf("v%0d_lat", i), lat, vecs[i].lat);
      chk($sformatf("v%0d_result", i), result, vecs[i].res);
      chk($sformatf("v%0d_zero", i), zero, vecs[i].z);
      chk($sformatf("v%0d_err", i), err, vecs[i].e);
      chk($sformatf("v%0d_px", i), mem[vecs[i].x], vecs[i].px);
      chk($sformatf("v%0d_py", i), mem[vecs[i].y], vecs[i].py);
      chk($sformatf("v%0d_nweh", i), nweh, vecs[i].nh);
      chk($sformatf("v%0d_nwel", i), nwel, vecs[i].nl);
      @(negedge clk);
      chk($sformatf("v%0d_back_idle", i), {ready, done, err}, 3'b100);
    end

    // XCHG 0<->2 (0=ABCD, 2=1234) with a 4-cycle stall in EXEC and a req while busy
    req = 1'b1; op = 3'd6; addr_x = 3'd0; addr_y = 3'd2; wdata = 16'h0000;
    @(negedge clk);
    cen = 1'b0;
    req = 1'b1; op = 3'd3; addr_x = 3'd7; wdata = 16'h9999;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("stall%0d_we", k), {rf_weh, rf_wel}, 2'b00);
      chk($sformatf("stall%0d_stat", k), {busy, done, ready}, 3'b100);
      chk($sformatf("stall%0d_rf_cen", k), rf_cen, 1'b0);
      chk($sformatf("stall%0d_mem0", k), mem[0], 16'hABCD);
    end
    req = 1'b0;
    cen = 1'b1;
    #1;
    chk("xchg_exec_addr", rf_addr_a, 3'd0);
    chk("xchg_exec_we", {rf_weh, rf_wel}, 2'b11);
    chk("xchg_exec_data", {rf_dih, rf_dil}, 16'h1234);
    @(negedge clk);
    chk("xchg_xch2_addr", rf_addr_a, 3'd2);
    chk("xchg_xch2_we", {rf_weh, rf_wel}, 2'b11);
    chk("xchg_xch2_data", {rf_dih, rf_dil}, 16'hABCD);
    @(negedge clk);
    chk("xchg_done", done, 1'b1);
    chk("xchg_result", result, 16'h1234);
    chk("xchg_mem0", mem[0], 16'h1234);
    chk("xchg_mem2", mem[2], 16'hABCD);
    chk("xchg_mem7", mem[7], 16'h0000);
    repeat (2) @(negedge clk);
    chk("no_queue", {ready, busy}, 2'b10);

    // XCHG 0<->2 again (0=1234, 2=ABCD), reset in XCH2
    req = 1'b1; op = 3'd6; addr_x = 3'd0; addr_y = 3'd2;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    chk("abort_in_xch2", busy, 1'b1);
    reset = 1'b1;
    #1;
    chk("abort_we", {rf_weh, rf_wel}, 2'b00);
    @(negedge clk);
    chk("abort_stat", {ready, done, busy}, 3'b100);
    chk("abort_result", result, 16'h0000);
    chk("abort_mem0", mem[0], 16'hABCD);
    chk("abort_mem2", mem[2], 16'hABCD);
    reset = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
